dmem_resp: RTL
==============

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the storage array; power of two.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  1  memory access request from the pipeline; held stable with all request fields until done.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 half  input  1  halfword access when 1.
REQ-007 b  input  1  byte access when 1; half and b both 0 = word access; both 1 is treated as byte.
REQ-008 bunsigned  input  1  loads of byte/halfword zero-extend when 1, sign-extend when 0.
REQ-009 addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2], modulo DEPTH.
REQ-010 wdata  input  32  store data; byte/halfword stores take the low 8/16 bits.
REQ-011 rdata  output  32  extended load result, registered.
REQ-012 stall  output  1  combinational; pipeline must freeze while high.
REQ-013 done  output  1  one-cycle pulse marking completion of the accepted request.
REQ-014 misalign  output  1  registered error flag (present only with DMEM_MISALIGN_TRAP_EN).

Function
REQ-015 States: IDLE, READ, MERGE, WRITE, DONE.
REQ-016 IDLE with req=1: request accepted; load -> READ; full-word store -> WRITE; byte/halfword store -> READ.
REQ-017 READ: array word fetched into internal register; load -> DONE; sub-word store -> MERGE.
REQ-018 MERGE: selected lane(s) of fetched word replaced by wdata low bits, others unchanged -> WRITE.
REQ-019 WRITE: merged or full word written to array -> DONE.
REQ-020 DONE: done=1 for exactly this cycle -> IDLE; req in DONE is not accepted until the following IDLE.
REQ-021 Latency accept-to-done: load 2 cycles, word store 2 cycles, byte/halfword store 4 cycles.
REQ-022 stall = (IDLE and req) or state in {READ, MERGE, WRITE}; stall=0 in DONE.
REQ-023 Little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1]; lane k occupies bits 8k+7:8k.
REQ-024 Load result: word = full word; halfword/byte = selected lane, extended per bunsigned; rdata updated on READ->DONE and held until next load completes.
REQ-025 Stores leave rdata unchanged.
REQ-026 Addresses beyond DEPTH words wrap modulo DEPTH; no error.
REQ-027 Request fields change while stall=1: behaviour undefined, no protection required.

Reset
REQ-028 reset=0 at a clock edge: state -> IDLE, rdata -> 0, done -> 0, misalign -> 0, internal read/merge registers -> 0.
REQ-029 Reset mid-operation aborts the access; a pending WRITE not yet reached leaves the array unmodified; array contents are not cleared by reset.
REQ-030 First request is accepted on the first edge with reset=1 and req=1.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 -> IDLE->DONE directly, array untouched, rdata unchanged, misalign=1 in DONE cycle only; latency 1.
REQ-032 Macro undefined: misalign port absent; misaligned low address bits ignored (halfword uses addr[1], word uses aligned word), access proceeds normally.

Verification
REQ-033 Word store addr=0x10 wdata=0xDEADBEEF, then word load addr=0x10 -> done 2 cycles after each accept, rdata=0xDEADBEEF.
REQ-034 Byte store addr=0x11 wdata=0x000000A5 over 0xDEADBEEF, then word load 0x10 -> 0xDEADA5EF; store done at 4 cycles.
REQ-035 Byte load addr=0x11 bunsigned=0 -> 0xFFFFFFA5; bunsigned=1 -> 0x000000A5; halfword load addr=0x12 bunsigned=0 -> 0xFFFFDEAD.
REQ-036 Word store addr=0x100 (DEPTH=64) then load addr=0x0 -> same data (wrap); stall high every cycle from accept through WRITE, low in DONE.
REQ-037 Sub-word store with reset=0 asserted in MERGE -> state IDLE, done=0, later word load returns original value.
REQ-038 With DMEM_MISALIGN_TRAP_EN: halfword load addr=0x13 -> done and misalign high 1 cycle after accept, rdata unchanged; without: same access returns halfword at lane addr[1]=1.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Request/response bundle between the pipeline (master) and dmem_resp (slave).
// The misalign flag only exists when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_resp_if;
  logic        req;
  logic        we;
  logic        half;
  logic        b;
  logic        bunsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output req, we, half, b, bunsigned, addr, wdata,
    input  rdata, stall, done, misalign
  );

  modport slave (
    input  req, we, half, b, bunsigned, addr, wdata,
    output rdata, stall, done, misalign
  );
`else
  modport master (
    output req, we, half, b, bunsigned, addr, wdata,
    input  rdata, stall, done
  );

  modport slave (
    input  req, we, half, b, bunsigned, addr, wdata,
    output rdata, stall, done
  );
`endif
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle data memory with byte/halfword/word access and read-modify-write stores.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_resp #(
  parameter int DEPTH = 64
) (
  input  logic  clk,
  input  logic  reset,
  dmem_resp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_fetch;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic [AW-1:0] w_index;
  logic [31:0] w_memWord;
  logic [7:0]  w_laneByte;
  logic [15:0] w_laneHalf;
  logic [31:0] w_loadData;
  logic [31:0] w_mergeData;
  logic        w_isByte;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_misaligned;
  logic        w_unused;

  // Byte wins when both size bits are set; word when neither is.
  assign w_isByte   = bus.b;
  assign w_isHalf   = bus.half & ~bus.b;
  assign w_isWord   = ~bus.half & ~bus.b;
  assign w_index    = bus.addr[AW+1:2];
  assign w_memWord  = r_mem[w_index];
  assign w_laneByte = w_memWord[{bus.addr[1:0], 3'b000} +: 8];
  assign w_laneHalf = w_memWord[{bus.addr[1], 4'b0000} +: 16];
  assign w_unused   = ^{bus.addr[31:AW+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misaligned = (w_isHalf & bus.addr[0]) | (w_isWord & (|bus.addr[1:0]));
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    w_loadData = w_memWord;
    if (w_isByte) begin
      w_loadData = {{24{~bus.bunsigned & w_laneByte[7]}}, w_laneByte};
    end else if (w_isHalf) begin
      w_loadData = {{16{~bus.bunsigned & w_laneHalf[15]}}, w_laneHalf};
    end
  end

  always_comb begin
    w_mergeData = r_fetch;
    if (w_isByte) begin
      w_mergeData[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
    end else if (w_isHalf) begin
      w_mergeData[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
    end
  end

  // Full-word stores skip the fetch; sub-word stores read-modify-write.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_misaligned)     w_nextState = DONE;
          else if (!bus.we)     w_nextState = READ;
          else if (w_isWord)    w_nextState = WRITE;
          else                  w_nextState = READ;
        end
      end
      READ:    w_nextState = bus.we ? MERGE : DONE;
      MERGE:   w_nextState = WRITE;
      WRITE:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_fetch <= '0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == READ) begin
        r_fetch <= w_memWord;
        if (!bus.we) r_rdata <= w_loadData;
      end
      if (r_state == MERGE) r_merge <= w_mergeData;
    end
  end

  // Storage is never cleared; a reset edge also suppresses a write in flight.
  always_ff @(posedge clk) begin
    if (reset && (r_state == WRITE)) begin
      r_mem[w_index] <= w_isWord ? bus.wdata : r_merge;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == IDLE) && bus.req && w_misaligned;
    end
  end

  assign bus.misalign = r_misalign;
`endif

  assign bus.rdata = r_rdata;
  assign bus.done  = (r_state == DONE);
  assign bus.stall = ((r_state == IDLE) && bus.req) ||
                     (r_state == READ) || (r_state == MERGE) || (r_state == WRITE);

endmodule
